// File: rtl/rf_commit_sequencer.sv
// Retire-to-register-file commit sequencer: buffers up to two retiring results per
// cycle, drains one per cycle to the commit port, and orders flushes behind commits.
module rf_commit_sequencer #(
    parameter int unsigned XLEN            = 32,
    parameter int unsigned REG_INDEX_WIDTH = 5,
    parameter int unsigned ROB_INDEX_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             retire0_valid,
    input  logic [REG_INDEX_WIDTH-1:0]       retire0_sel,
    input  logic [XLEN-1:0]                  retire0_data,
    input  logic [ROB_INDEX_WIDTH-1:0]       retire0_ROB_index,
    input  logic                             retire1_valid,
    input  logic [REG_INDEX_WIDTH-1:0]       retire1_sel,
    input  logic [XLEN-1:0]                  retire1_data,
    input  logic [ROB_INDEX_WIDTH-1:0]       retire1_ROB_index,
    output logic                             retire_ready,
    input  logic                             flush_request,
    output logic                             commit_enable,
    output logic [REG_INDEX_WIDTH-1:0]       commit_sel,
    output logic [XLEN-1:0]                  commit_data,
    output logic [ROB_INDEX_WIDTH-1:0]       commit_ROB_index,
    output logic                             flush,
    output logic                             flush_done,
    output logic [$clog2(FIFO_DEPTH):0]      occupancy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned OW = PW + 1;
    localparam logic [OW-1:0] DEPTH_C = OW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    typedef struct packed {
        logic [REG_INDEX_WIDTH-1:0] sel;
        logic [XLEN-1:0]            data;
        logic [ROB_INDEX_WIDTH-1:0] rob;
    } entry_t;

    state_t  r_state;
    state_t  w_state_next;
    entry_t  r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [OW-1:0] r_occ;
    logic          r_commit_enable;
    entry_t        r_commit;

    logic          w_ready;
    logic          w_acc0;
    logic          w_acc1;
    logic          w_pop;
    logic [OW-1:0] w_n_acc;
    logic [PW-1:0] w_wptr1;
    entry_t        w_lane0;
    entry_t        w_lane1;

    assign w_ready = (r_state == S_RUN) && ((DEPTH_C - r_occ) >= OW'(2));
    // x0 writes are architecturally void, so they never take a slot
    assign w_acc0  = w_ready && retire0_valid && (retire0_sel != '0);
    assign w_acc1  = w_ready && retire0_valid && retire1_valid && (retire1_sel != '0);
    assign w_pop   = (r_occ != '0);
    assign w_n_acc = OW'(w_acc0) + OW'(w_acc1);
    assign w_wptr1 = r_wptr + PW'(w_acc0);

    assign w_lane0 = '{sel: retire0_sel, data: retire0_data, rob: retire0_ROB_index};
    assign w_lane1 = '{sel: retire1_sel, data: retire1_data, rob: retire1_ROB_index};

    always_ff @(posedge clock) begin
        if (w_acc0) r_mem[r_wptr]  <= w_lane0;
        if (w_acc1) r_mem[w_wptr1] <= w_lane1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_occ           <= '0;
            r_commit_enable <= 1'b0;
            r_commit        <= '0;
        end else begin
            r_wptr          <= r_wptr + PW'(w_n_acc);
            r_occ           <= r_occ + w_n_acc - OW'(w_pop);
            r_commit_enable <= w_pop;
            if (w_pop) begin
                r_commit <= r_mem[r_rptr];
                r_rptr   <= r_rptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) r_state <= S_RUN;
        else        r_state <= w_state_next;
    end

    // ISSUE waits for the final commit strobe to retire, so flush never overlaps a write
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN:   if (flush_request) w_state_next = S_DRAIN;
            S_DRAIN: if ((r_occ == '0) && !r_commit_enable) w_state_next = S_ISSUE;
            S_ISSUE: w_state_next = S_RUN;
            default: w_state_next = S_RUN;
        endcase
    end

    assign retire_ready     = w_ready;
    assign commit_enable    = r_commit_enable;
    assign commit_sel       = r_commit.sel;
    assign commit_data      = r_commit.data;
    assign commit_ROB_index = r_commit.rob;
    assign flush            = (r_state == S_ISSUE);
    assign flush_done       = (r_state == S_ISSUE);
    assign occupancy        = r_occ;

endmodule

// File: tb/tb_rf_commit_sequencer.sv
// Bench for rf_commit_sequencer: vector table plus hand sequences, with a commit
// scoreboard fed at retire time and drained as commits appear.
module tb_rf_commit_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        retire0_valid;
    logic [4:0]  retire0_sel;
    logic [31:0] retire0_data;
    logic [7:0]  retire0_ROB_index;
    logic        retire1_valid;
    logic [4:0]  retire1_sel;
    logic [31:0] retire1_data;
    logic [7:0]  retire1_ROB_index;
    logic        retire_ready;
    logic        flush_request;
    logic        commit_enable;
    logic [4:0]  commit_sel;
    logic [31:0] commit_data;
    logic [7:0]  commit_ROB_index;
    logic        flush;
    logic        flush_done;
    logic [2:0]  occupancy;

    rf_commit_sequencer #(
        .XLEN(32), .REG_INDEX_WIDTH(5), .ROB_INDEX_WIDTH(8), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset),
        .retire0_valid(retire0_valid), .retire0_sel(retire0_sel),
        .retire0_data(retire0_data), .retire0_ROB_index(retire0_ROB_index),
        .retire1_valid(retire1_valid), .retire1_sel(retire1_sel),
        .retire1_data(retire1_data), .retire1_ROB_index(retire1_ROB_index),
        .retire_ready(retire_ready), .flush_request(flush_request),
        .commit_enable(commit_enable), .commit_sel(commit_sel),
        .commit_data(commit_data), .commit_ROB_index(commit_ROB_index),
        .flush(flush), .flush_done(flush_done), .occupancy(occupancy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
        logic [7:0]  rob;
    } exp_t;

    typedef struct {
        logic        v0;
        logic [4:0]  s0;
        logic [31:0] d0;
        logic [7:0]  r0;
        logic        v1;
        logic [4:0]  s1;
        logic [31:0] d1;
        logic [7:0]  r1;
        int unsigned exp_occ;
    } vec_t;

    typedef enum int {M_RUN, M_DRAIN, M_ISSUE} mstate_t;

    exp_t        sb[$];
    vec_t        vecs[7];
    mstate_t     m_state;
    int unsigned m_occ;
    logic        m_ce;
    exp_t        m_last;
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          flush_cnt;
    int          commit_cnt;
    int          last_commit_cyc;
    int          last_flush_cyc;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic v0, input logic [4:0] s0, input logic [31:0] d0, input logic [7:0] r0,
                        input logic v1, input logic [4:0] s1, input logic [31:0] d1, input logic [7:0] r1,
                        input logic fr);
        logic        exp_ready;
        logic        pop;
        int unsigned acc;
        mstate_t     nstate;
        exp_t        e;
        exp_ready = (m_state == M_RUN) && (DEPTH - m_occ >= 2);
        check("retire_ready", retire_ready, exp_ready);
        acc = 0;
        if (exp_ready && v0) begin
            if (s0 != 0) begin e.sel = s0; e.data = d0; e.rob = r0; sb.push_back(e); acc++; end
            if (v1 && s1 != 0) begin e.sel = s1; e.data = d1; e.rob = r1; sb.push_back(e); acc++; end
        end
        retire0_valid = v0; retire0_sel = s0; retire0_data = d0; retire0_ROB_index = r0;
        retire1_valid = v1; retire1_sel = s1; retire1_data = d1; retire1_ROB_index = r1;
        flush_request = fr;
        @(posedge clock);
        #1;
        retire0_valid = 1'b0; retire1_valid = 1'b0; flush_request = 1'b0;
        cyc++;
        nstate = m_state;
        case (m_state)
            M_RUN:   if (fr) nstate = M_DRAIN;
            M_DRAIN: if (m_occ == 0 && !m_ce) nstate = M_ISSUE;
            default: nstate = M_RUN;
        endcase
        pop = (m_occ != 0);
        m_occ = m_occ + acc - (pop ? 1 : 0);
        m_ce = pop;
        m_state = nstate;
        check("occupancy", occupancy, m_occ);
        check("commit_enable", commit_enable, m_ce);
        check("flush", flush, m_state == M_ISSUE);
        check("flush_done", flush_done, m_state == M_ISSUE);
        if (flush) begin flush_cnt++; last_flush_cyc = cyc; end
        if (commit_enable) begin
            commit_cnt++;
            last_commit_cyc = cyc;
            if (sb.size() == 0) begin
                check("commit_unexpected", 1, 0);
            end else begin
                e = sb.pop_front();
                check("commit_sel", commit_sel, e.sel);
                check("commit_data", commit_data, e.data);
                check("commit_rob", commit_ROB_index, e.rob);
                m_last = e;
            end
        end else begin
            check("hold_sel", commit_sel, m_last.sel);
            check("hold_data", commit_data, m_last.data);
            check("hold_rob", commit_ROB_index, m_last.rob);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle(input string name);
        int n;
        n = 0;
        while (!(m_state == M_RUN && m_occ == 0 && !m_ce) && n < 40) begin
            idle(1);
            n++;
        end
        if (n >= 40) check({name, "_timeout"}, 1, 0);
    endtask

    task automatic do_reset(input int edges);
        reset = 1'b0;
        retire0_valid = 1'b0; retire1_valid = 1'b0; flush_request = 1'b0;
        repeat (edges) @(posedge clock);
        #1;
        reset = 1'b1;
        cyc++;
        m_occ = 0; m_state = M_RUN; m_ce = 1'b0; m_last = '0;
        sb.delete();
        check("rst_commit_enable", commit_enable, 0);
        check("rst_commit_sel", commit_sel, 0);
        check("rst_commit_data", commit_data, 0);
        check("rst_commit_rob", commit_ROB_index, 0);
        check("rst_flush", flush, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_retire_ready", retire_ready, 1);
    endtask

    initial begin
        int f0;
        int c0;
        n_checks = 0; n_fail = 0; cyc = 0;
        flush_cnt = 0; commit_cnt = 0; last_commit_cyc = 0; last_flush_cyc = 0;
        retire0_sel = '0; retire0_data = '0; retire0_ROB_index = '0;
        retire1_sel = '0; retire1_data = '0; retire1_ROB_index = '0;

        vecs[0] = '{1'b1, 5'd1,  32'd15,         8'd5,   1'b0, 5'd0,  32'd0,  8'd0,  1};
        vecs[1] = '{1'b1, 5'd2,  32'd30,         8'd4,   1'b1, 5'd3,  32'd40, 8'd6,  2};
        vecs[2] = '{1'b1, 5'd0,  32'd99,         8'd1,   1'b1, 5'd7,  32'd8,  8'd2,  1};
        vecs[3] = '{1'b0, 5'd9,  32'd11,         8'd3,   1'b1, 5'd10, 32'd12, 8'd4,  0};
        vecs[4] = '{1'b1, 5'd0,  32'd1,          8'd1,   1'b1, 5'd0,  32'd2,  8'd2,  0};
        vecs[5] = '{1'b1, 5'd31, 32'hFFFF_FFFF,  8'hFF,  1'b1, 5'd0,  32'd5,  8'd9,  1};
        vecs[6] = '{1'b1, 5'd30, 32'hA5A5_5A5A,  8'h80,  1'b1, 5'd31, 32'd0,  8'h7F, 2};

        do_reset(2);

        for (int v = 0; v < 7; v++) begin
            step(vecs[v].v0, vecs[v].s0, vecs[v].d0, vecs[v].r0,
                 vecs[v].v1, vecs[v].s1, vecs[v].d1, vecs[v].r1, 1'b0);
            check($sformatf("vec%0d_occ", v), occupancy, vecs[v].exp_occ);
            settle($sformatf("vec%0d", v));
        end

        // single retire: one-cycle commit strobe two edges after acceptance
        c0 = commit_cnt;
        step(1, 5'd1, 32'd15, 8'd5, 0, 0, 0, 0, 0);
        check("lat_ce_after_E", commit_enable, 0);
        idle(1);
        check("lat_ce_after_E1", commit_enable, 1);
        check("lat_sel", commit_sel, 1);
        idle(1);
        check("lat_ce_one_cycle", commit_enable, 0);
        check("lat_commits", commit_cnt - c0, 1);

        // backpressure: both lanes valid every cycle
        for (int k = 0; k < 16; k++) begin
            logic [4:0] sa;
            logic [4:0] sbb;
            sa  = 5'((2 * k) % 31 + 1);
            sbb = 5'((2 * k + 1) % 31 + 1);
            step(1, sa, 32'(1000 + 2 * k), 8'(2 * k), 1, sbb, 32'(1001 + 2 * k), 8'(2 * k + 1), 0);
        end
        settle("bp");

        // flush sequencing: older retires, then a retire alongside the flush request
        f0 = flush_cnt;
        c0 = commit_cnt;
        step(1, 5'd4, 32'd400, 8'd40, 1, 5'd5, 32'd500, 8'd50, 0);
        step(1, 5'd6, 32'd600, 8'd60, 0, 0, 0, 0, 0);
        step(1, 5'd8, 32'd800, 8'd80, 0, 0, 0, 0, 1);
        step(1, 5'd9, 32'd900, 8'd90, 0, 0, 0, 0, 1);
        settle("flush");
        check("flush_commits", commit_cnt - c0, 4);
        check("flush_pulses", flush_cnt - f0, 1);
        check("flush_after_commit", last_flush_cyc > last_commit_cyc, 1);
        check("ready_after_flush", retire_ready, 1);

        // reset while draining with three entries buffered
        f0 = flush_cnt;
        step(1, 5'd10, 32'd10, 8'd1, 1, 5'd11, 32'd11, 8'd2, 0);
        step(1, 5'd12, 32'd12, 8'd3, 1, 5'd13, 32'd13, 8'd4, 1);
        check("drain_occ3", occupancy, 3);
        do_reset(1);
        idle(4);
        check("rst_drain_no_flush", flush_cnt - f0, 0);

        step(1, 5'd20, 32'hDEAD_BEEF, 8'h22, 0, 0, 0, 0, 0);
        settle("post_reset");
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_commit_sequencer.md
Name: rf_commit_sequencer

Overview:
- Sits between the reorder buffer retire logic and the register file's single commit port.
- Accepts up to two retiring results per cycle, buffers them in order, and drains exactly one per cycle into the register file.
- Sequences pipeline flushes so the register file flush is raised only after every already-retired result has been written.

Parameters:
XLEN, 32, register data width
REG_INDEX_WIDTH, 5, architectural register select width
ROB_INDEX_WIDTH, 8, ROB tag width
FIFO_DEPTH, 4, retire buffer entries; power of two, >= 2

Ports:
clock  input  1  single clock; all state updates on posedge
reset  input  1  synchronous, active-low; sampled on posedge, state cleared while low
retire0_valid  input  1  lane 0 retire request
retire0_sel  input  REG_INDEX_WIDTH  lane 0 destination register
retire0_data  input  XLEN  lane 0 result
retire0_ROB_index  input  ROB_INDEX_WIDTH  lane 0 ROB tag
retire1_valid  input  1  lane 1 retire request; only legal with retire0_valid
retire1_sel  input  REG_INDEX_WIDTH  lane 1 destination register
retire1_data  input  XLEN  lane 1 result
retire1_ROB_index  input  ROB_INDEX_WIDTH  lane 1 ROB tag
retire_ready  output  1  both lanes accepted this cycle when high
flush_request  input  1  single-cycle flush request from ROB
commit_enable  output  1  register file commit strobe
commit_sel  output  REG_INDEX_WIDTH  register file commit select
commit_data  output  XLEN  register file commit data
commit_ROB_index  output  ROB_INDEX_WIDTH  register file commit ROB tag
flush  output  1  register file flush, one-cycle pulse
flush_done  output  1  one-cycle pulse, coincident with flush
occupancy  output  clog2(FIFO_DEPTH)+1  current buffered entry count

Behaviour:
- Reset (reset==0 at posedge): FIFO emptied, pointers 0, state RUN. commit_enable, commit_sel, commit_data, commit_ROB_index, flush and flush_done all 0. occupancy 0.
- retire_ready = (state==RUN) && (FIFO_DEPTH - occupancy >= 2). The term is combinational from registered state only; it never depends on the valid inputs.
- Acceptance: at a posedge where retire_ready && retire0_valid, lane 0 is enqueued.
  - If retire1_valid is also high, lane 1 is enqueued behind lane 0. Program order is lane 0, then lane 1.
  - A lane with sel==0 (x0) is discarded at enqueue and occupies no slot.
  - retire1_valid without retire0_valid is ignored.
- Drain: at each posedge where the FIFO is non-empty, the head is popped into the commit output registers and commit_enable is set to 1. Otherwise commit_enable is set to 0.
  - commit_sel, commit_data and commit_ROB_index hold their last values when commit_enable is 0.
- Enqueue and pop may occur at the same edge; occupancy is updated by +accepted-1.
- Latency: an entry enqueued at edge E into an empty FIFO is popped at edge E+1. commit_enable is high in the cycle following E+1. Throughput is 1 commit per cycle.
- Pointer wrap: read and write pointers wrap modulo FIFO_DEPTH. Full/empty is determined from occupancy.
- State machine:
  - RUN: on flush_request, go to DRAIN. A retire beat accepted at that same edge is kept, because it is older than the flush.
  - DRAIN: retire_ready=0; keep popping. When occupancy==0 and commit_enable==0, go to ISSUE.
  - ISSUE: flush=1 and flush_done=1 for exactly this cycle, then RUN.
- flush_request while in DRAIN or ISSUE is ignored, with no queued second flush.
- Commit and flush never coincide: flush is raised only after the last commit cycle has completed.
- Reset low mid-DRAIN or mid-stream: buffered entries are dropped, no flush is issued, and the next state is RUN.

Test Plan:
- Single retire: lane0 {sel=1, data=15, ROB=5} accepted at edge E -> commit_enable=1 with sel=1, data=15, ROB=5 in the cycle after E+1, for exactly one cycle; occupancy returns to 0.
- Dual retire with ordering: lane0 {2, 30, 4} + lane1 {3, 40, 6} in the same cycle -> commits on consecutive cycles, first sel=2, then sel=3.
- x0 filtering: lane0 {sel=0, data=99} + lane1 {sel=7, data=8} -> only sel=7 commits; occupancy peaks at 1.
- Backpressure/full: DEPTH=4, hold both lanes valid every cycle -> retire_ready drops whenever occupancy >= 3; no entry lost; commits are a contiguous sequence of 1 per cycle in program order.
- Flush sequencing: three entries buffered, then flush_request pulse with a lane0 retire in the same cycle -> all four commit first; retire_ready=0 throughout DRAIN; flush and flush_done pulse once, one or more cycles after the last commit_enable; then retire_ready is high again.
- Reset mid-drain: reset=0 for one edge while occupancy=3 in DRAIN -> commit_enable=0 next cycle, occupancy=0, no flush pulse, retire_ready=1.
